// File: rtl/board_scan_ctrl.sv
// Board RAM scan controller: fetches one board row per video line into a line register
// and arbitrates the shared RAM port with the game engine. Optional macro: FRAME_LOCK_EN.
module board_scan_ctrl #(
   parameter int COLS       = 20,
   parameter int ROWS       = 10,
   parameter int AW         = 4,
   parameter int CELL_LOG2  = 4,
   parameter int MAT_X0     = 16,
   parameter int MAT_Y0     = 16,
   parameter int FETCH_HCNT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     h_cnt,
   input  logic [11:0]     active_x,
   input  logic [11:0]     active_y,
   output logic            temp_bit,
   input  logic            game_req,
   input  logic            game_we,
   input  logic [AW-1:0]   game_addr,
   input  logic [COLS-1:0] game_wdata,
   output logic            game_gnt,
   output logic            game_rvalid,
   output logic [COLS-1:0] game_rdata,
   output logic            ram_en,
   output logic            ram_we,
   output logic [AW-1:0]   ram_addr,
   output logic [COLS-1:0] ram_wdata,
   input  logic [COLS-1:0] ram_rdata
);
   localparam int          CW     = $clog2(COLS);
   localparam logic [11:0] X0     = 12'(MAT_X0);
   localparam logic [11:0] Y0     = 12'(MAT_Y0);
   localparam logic [11:0] X_END  = 12'(MAT_X0 + (COLS << CELL_LOG2));
   localparam logic [11:0] Y_END  = 12'(MAT_Y0 + (ROWS << CELL_LOG2));
   localparam logic [11:0] TRIG_H = 12'(FETCH_HCNT);
   localparam logic [AW:0] ROWS_W = (AW+1)'(ROWS);

   typedef enum logic [1:0] {IDLE, DISP_RD, DISP_CAP, GAME_CAP} state_t;

   state_t          state_q, state_d;
   logic            fetch_pend_q, fetch_pend_d;
   logic [AW-1:0]   row_q, row_d;
   logic [COLS-1:0] line_q, line_d;
   logic            temp_bit_q, temp_bit_d;
   logic            game_gnt_q, game_gnt_d;
   logic            game_rvalid_q, game_rvalid_d;
   logic            rd_ok_q, rd_ok_d;
   logic            ram_en_q, ram_en_d;
   logic            ram_we_q, ram_we_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic [COLS-1:0] ram_wdata_q, ram_wdata_d;

   logic [11:0]   x_off, y_off;
   logic [CW-1:0] x_col;
   logic [AW-1:0] y_row;
   logic          in_x, in_y, trig, addr_ok, wr_ok, fetch_go, can_grant;

   always_comb begin
      x_off     = active_x - X0;
      y_off     = active_y - Y0;
      x_col     = x_off[CW+CELL_LOG2-1:CELL_LOG2];
      y_row     = y_off[AW+CELL_LOG2-1:CELL_LOG2];
      in_x      = (active_x >= X0) && (active_x < X_END);
      in_y      = (active_y >= Y0) && (active_y < Y_END);
      trig      = (h_cnt == TRIG_H);
      addr_ok   = ({1'b0, game_addr} < ROWS_W);
`ifdef FRAME_LOCK_EN
      // writes only land while the beam is outside the matrix rows
      wr_ok     = !in_y;
`else
      wr_ok     = 1'b1;
`endif
      fetch_go  = fetch_pend_q || (trig && in_y);
      // the previous-cycle gnt guard stops a still-held req from being accepted twice
      can_grant = game_req && !trig && !fetch_pend_q && !game_gnt_q && (!game_we || wr_ok);
   end

   always_comb begin
      state_d       = state_q;
      fetch_pend_d  = fetch_pend_q;
      row_d         = row_q;
      line_d        = line_q;
      game_gnt_d    = 1'b0;
      game_rvalid_d = 1'b0;
      rd_ok_d       = rd_ok_q;
      ram_en_d      = 1'b0;
      ram_we_d      = 1'b0;
      ram_addr_d    = '0;
      ram_wdata_d   = '0;
      temp_bit_d    = in_x ? line_q[x_col] : 1'b0;

      if (trig) begin
         if (in_y) begin
            fetch_pend_d = 1'b1;
            row_d        = y_row;
         end else begin
            line_d = '0;
         end
      end

      case (state_q)
         IDLE: begin
            if (fetch_go) begin
               state_d    = DISP_RD;
               ram_en_d   = 1'b1;
               ram_addr_d = fetch_pend_q ? row_q : y_row;
            end else if (can_grant) begin
               game_gnt_d = 1'b1;
               ram_en_d   = addr_ok;
               ram_addr_d = game_addr;
               if (game_we) begin
                  ram_we_d    = addr_ok;
                  ram_wdata_d = game_wdata;
               end else begin
                  rd_ok_d = addr_ok;
                  state_d = GAME_CAP;
               end
            end
         end
         DISP_RD:  state_d = DISP_CAP;
         DISP_CAP: begin
            line_d       = ram_rdata;
            fetch_pend_d = 1'b0;
            state_d      = IDLE;
         end
         GAME_CAP: begin
            game_rvalid_d = 1'b1;
            state_d       = IDLE;
         end
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         fetch_pend_q  <= 1'b0;
         row_q         <= '0;
         line_q        <= '0;
         temp_bit_q    <= 1'b0;
         game_gnt_q    <= 1'b0;
         game_rvalid_q <= 1'b0;
         rd_ok_q       <= 1'b0;
         ram_en_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pend_q  <= fetch_pend_d;
         row_q         <= row_d;
         line_q        <= line_d;
         temp_bit_q    <= temp_bit_d;
         game_gnt_q    <= game_gnt_d;
         game_rvalid_q <= game_rvalid_d;
         rd_ok_q       <= rd_ok_d;
         ram_en_q      <= ram_en_d;
         ram_we_q      <= ram_we_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
      end
   end

   // read data comes straight off the RAM in the rvalid cycle; out-of-range rows read as zero
   assign game_rdata  = (game_rvalid_q && rd_ok_q) ? ram_rdata : '0;
   assign temp_bit    = temp_bit_q;
   assign game_gnt    = game_gnt_q;
   assign game_rvalid = game_rvalid_q;
   assign ram_en      = ram_en_q;
   assign ram_we      = ram_we_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
endmodule

// File: tb/tb_board_scan_ctrl.sv
// Bench for board_scan_ctrl: behavioural board/line model with a per-cycle compare process,
// a 1-cycle-latency RAM, and directed video lines with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_board_scan_ctrl;
   localparam int COLS = 20, ROWS = 10, AW = 4, LINE = 360;
   localparam int S_TEMP = 0, S_EN = 1, S_ADDR = 2, S_GNT = 3, S_RV = 4, S_RD = 5, S_WE = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic [11:0]     h_cnt = '0, active_x = '0, active_y = '0;
   logic            temp_bit;
   logic            game_req = 1'b0, game_we = 1'b0;
   logic [AW-1:0]   game_addr = '0;
   logic [COLS-1:0] game_wdata = '0;
   logic            game_gnt, game_rvalid;
   logic [COLS-1:0] game_rdata;
   logic            ram_en, ram_we;
   logic [AW-1:0]   ram_addr;
   logic [COLS-1:0] ram_wdata;
   logic [COLS-1:0] ram_rdata;

   always #5 clk = ~clk;

   board_scan_ctrl dut (
      .clk(clk), .rst(rst), .h_cnt(h_cnt), .active_x(active_x), .active_y(active_y),
      .temp_bit(temp_bit), .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
      .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rvalid(game_rvalid),
      .game_rdata(game_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   function automatic logic [COLS-1:0] init_val(input int i);
      case (i)
         0:       return 20'h00001;
         1:       return 20'h5A5A5;
         3:       return 20'hABCDE;
         default: return 20'(i * 32'h1111) ^ 20'h0F0F0;
      endcase
   endfunction

   // RAM environment
   logic [COLS-1:0] mem [16];
   bit mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
         mem_init <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int at; int sig; logic [63:0] exp; string nm; } lit_t;
   lit_t lits[$];

   task automatic push(input int at, input int sig, input logic [63:0] e, input string nm);
      lit_t l;
      l.at = at; l.sig = sig; l.exp = e; l.nm = nm;
      lits.push_back(l);
   endtask

   function automatic logic [63:0] get_sig(input int s);
      case (s)
         S_TEMP:  return 64'(temp_bit);
         S_EN:    return 64'(ram_en);
         S_ADDR:  return 64'(ram_addr);
         S_GNT:   return 64'(game_gnt);
         S_RV:    return 64'(game_rvalid);
         S_RD:    return 64'(game_rdata);
         S_WE:    return 64'(ram_we);
         default: return 64'(mem[s-100]);
      endcase
   endfunction

   function automatic logic model_temp(input logic [COLS-1:0] ln, input int x);
      if (x >= 16 && x < 16 + COLS * 16) return ln[(x - 16) / 16];
      return 1'b0;
   endfunction

   // ---------------- behavioural model and compare process ----------------
   int nchk = 0, npass = 0;
   logic [COLS-1:0] board_m [16];
   bit bm_init = 1'b0;
   logic [COLS-1:0] exp_line = '0;
   int trig_cyc = -100, prev_x = 0, yy;
   logic prev_req = 1'b0, was_rd = 1'b0, ok;
   logic [COLS-1:0] pend_data = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (!bm_init) begin
         for (int i = 0; i < 16; i++) board_m[i] = init_val(i);
         bm_init = 1'b1;
      end
      foreach (lits[k]) if (lits[k].at == cyc) chk(lits[k].nm, get_sig(lits[k].sig), lits[k].exp);
      if (rst) begin
         chk("reset_outputs", {temp_bit, game_gnt, game_rvalid, game_rdata, ram_en, ram_we,
                               ram_addr, ram_wdata}, 64'd0);
         exp_line = '0; trig_cyc = -100; was_rd = 1'b0; pend_data = '0;
      end else begin
         if (cyc >= trig_cyc + 5) chk("temp_bit", 64'(temp_bit), 64'(model_temp(exp_line, prev_x)));
         chk("rvalid", 64'(game_rvalid), 64'(was_rd));
         if (was_rd) chk("rdata", 64'(game_rdata), 64'(pend_data));
         was_rd = 1'b0;
         if (game_gnt) begin
            chk("gnt_needs_req", 64'(prev_req), 64'd1);
            ok = (int'(game_addr) < ROWS);
            if (!ok) chk("oor_no_ram", 64'(ram_en), 64'd0);
            else if (game_we) chk("wr_port", {ram_en, ram_we, ram_addr, ram_wdata},
                                  {1'b1, 1'b1, game_addr, game_wdata});
            else chk("rd_port", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, game_addr});
            if (!game_we) begin
               was_rd    = 1'b1;
               pend_data = ok ? board_m[game_addr] : '0;
            end else if (ok) begin
               board_m[game_addr] = game_wdata;
            end
         end
         if (h_cnt == 12'd4) begin
            trig_cyc = cyc;
            yy = int'(active_y);
            exp_line = (yy >= 16 && yy < 16 + ROWS * 16) ? board_m[(yy - 16) / 16] : '0;
         end
      end
      prev_x   = int'(active_x);
      prev_req = game_req;
   end

   // ---------------- stimulus ----------------
   task automatic step(input int y, input int h);
      @(posedge clk); #1;
      if (game_gnt) game_req = 1'b0;
      active_y = 12'(y);
      h_cnt    = 12'(h);
      active_x = (h < 8) ? 12'd0 : 12'(h - 8);
   endtask

   task automatic req(input logic we, input logic [AW-1:0] a, input logic [COLS-1:0] d);
      game_req = 1'b1; game_we = we; game_addr = a; game_wdata = d;
   endtask

   task automatic line(input int y, input int mode);
      int c;
      for (int h = 0; h < LINE; h++) begin
         step(y, h);
         c = cyc;
         case (mode)
            1: begin
               if (h == 4) begin
                  push(c + 1, S_EN, 1, "t2_ram_en");
                  push(c + 1, S_ADDR, 0, "t2_ram_addr");
               end
               if (h == 24) push(c + 1, S_TEMP, 1, "t2_temp_x16");
               if (h == 40) push(c + 1, S_TEMP, 0, "t2_temp_x32");
            end
            2: begin
               if (h == 5) begin
                  rst = 1'b1;
                  push(c, S_EN, 0, "rst_ram_en");
               end
               if (h == 7) rst = 1'b0;
               if (h == 24) push(c + 1, S_TEMP, 0, "rst_line_cleared");
            end
            3: begin
               if (h == 4) begin
                  push(c + 1, S_EN, 0, "t5_no_fetch_a");
                  push(c + 2, S_EN, 0, "t5_no_fetch_b");
               end
               if (h == 100) begin
                  req(1'b0, 4'd3, '0);
                  push(c + 1, S_GNT, 1, "t3_gnt");
                  push(c + 2, S_RV, 1, "t3_rvalid");
                  push(c + 2, S_RD, 64'h ABCDE, "t3_rdata");
               end
               if (h == 200) begin
                  req(1'b1, 4'd12, 20'hFFFFF);
                  push(c + 1, S_GNT, 1, "oor_wr_gnt");
                  push(c + 1, S_EN, 0, "oor_wr_drop");
               end
               if (h == 220) begin
                  req(1'b0, 4'd15, '0);
                  push(c + 2, S_RV, 1, "oor_rd_rvalid");
                  push(c + 2, S_RD, 0, "oor_rd_zero");
               end
            end
            4: begin
               if (h == 3) begin
                  req(1'b0, 4'd1, '0);
                  push(c + 1, S_GNT, 1, "t4_gnt");
                  push(c + 2, S_RV, 1, "t4_rvalid");
                  push(c + 2, S_RD, 64'h5A5A5, "t4_rdata");
                  push(c + 2, S_EN, 0, "t4_fetch_deferred");
                  push(c + 3, S_EN, 1, "t4_fetch_en");
                  push(c + 3, S_ADDR, 1, "t4_fetch_addr");
               end
               if (h == 24) push(c + 1, S_TEMP, 1, "t4_temp_col0");
            end
            5: begin
               if (h == 100) begin
                  req(1'b1, 4'd5, 20'h12345);
`ifdef FRAME_LOCK_EN
                  push(c + 1, S_GNT, 0, "t6_lock_hold");
`else
                  push(c + 1, S_GNT, 1, "t6_gnt");
                  push(c + 1, S_WE, 1, "t6_ram_we");
`endif
               end
            end
            6: begin
               if (h == 24) push(c + 1, S_TEMP, 0, "row3_col0");
               if (h == 56) push(c + 1, S_TEMP, 1, "row3_col2");
            end
            7: if (h == 24) push(c + 1, S_TEMP, 1, "t6_row5_col0");
            default: ;
         endcase
      end
   endtask

   initial begin
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) step(200, 0);
      rst = 1'b0;
      line(16, 1);
      line(20, 2);
      line(200, 3);
      line(40, 4);
      line(64, 6);
      line(50, 5);
      line(180, 0);
      line(99, 7);
      step(200, 0);
      push(cyc + 1, 105, 64'h12345, "t6_mem_row5");
      repeat (4) step(200, 1);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
